// File: rtl/ipm_distributed_fifo_fwft_pkg.sv
// Shared constants for the distributed FIFO first-word-fall-through read stage.
package ipm_distributed_fifo_fwft_pkg;

    localparam int FWFT_BUF_DEPTH = 4;
    localparam int FWFT_PTR_W     = 2;
    localparam int FWFT_CNT_W     = 3;

    // Occupancy value meaning every skid-buffer entry holds a word.
    localparam logic [FWFT_CNT_W-1:0] FWFT_FULL_COUNT = FWFT_CNT_W'(FWFT_BUF_DEPTH);

    // Supported FIFO read latencies: 0 (OUT_REG=0) or 1 (OUT_REG=1).
    localparam int FWFT_RD_LATENCY_MIN = 0;
    localparam int FWFT_RD_LATENCY_MAX = 1;

    function automatic bit fwft_latency_legal(input int latency);
        return (latency >= FWFT_RD_LATENCY_MIN) && (latency <= FWFT_RD_LATENCY_MAX);
    endfunction

endpackage

// File: rtl/ipm_distributed_fifo_skid_buf_v1_0.sv
// Four-entry register skid buffer: circular array, wrapping pointers, occupancy count.
module ipm_distributed_fifo_skid_buf_v1_0
    import ipm_distributed_fifo_fwft_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] head_data,
    output logic [FWFT_CNT_W-1:0] count
);

    logic [DATA_WIDTH-1:0] mem [FWFT_BUF_DEPTH];
    logic [FWFT_PTR_W-1:0] wr_ptr;
    logic [FWFT_PTR_W-1:0] rd_ptr;

    // Store pushed words, advance pointers, and track occupancy; simultaneous push and pop keep the count.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < FWFT_BUF_DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign head_data = mem[rd_ptr];

    // The upstream credit logic must never let a word arrive into a full buffer.
    assert property (@(posedge clk) disable iff (rst) !(push && (count == FWFT_FULL_COUNT)));

endmodule

// File: rtl/ipm_distributed_fifo_fwft_rd_v1_0.sv
// FWFT read stage: turns the FIFO pop interface into a valid/ready stream using credit-controlled prefetch.
module ipm_distributed_fifo_fwft_rd_v1_0
    import ipm_distributed_fifo_fwft_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int RD_LATENCY = 0
) (
    input  logic                  rd_clk,
    input  logic                  rd_rst,
    output logic                  fifo_rd_en,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [2:0]            buf_level
);

    localparam bit LATENCY_OK = fwft_latency_legal(RD_LATENCY);

    logic                  inflight;
    logic                  push;
    logic                  pop;
    logic [FWFT_CNT_W-1:0] count;
    logic [FWFT_CNT_W-1:0] credit_used;

    // Words already buffered plus the one still travelling out of the FIFO consume credits;
    // m_ready is deliberately absent so the pop request never depends on the consumer combinationally.
    assign credit_used = count + {{(FWFT_CNT_W-1){1'b0}}, inflight};
    assign fifo_rd_en  = ~rd_rst & ~fifo_empty & (credit_used < FWFT_FULL_COUNT);

    if (RD_LATENCY == 1) begin : g_lat1
        // A pop accepted on this edge returns its word on the next edge.
        always_ff @(posedge rd_clk) begin
            if (rd_rst) begin
                inflight <= 1'b0;
            end else begin
                inflight <= fifo_rd_en;
            end
        end
        assign push = inflight;
    end else begin : g_lat0
        assign inflight = 1'b0;
        assign push     = fifo_rd_en;
    end

    assign pop = m_valid & m_ready;

    ipm_distributed_fifo_skid_buf_v1_0 #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_skid_buf (
        .clk       (rd_clk),
        .rst       (rd_rst),
        .push      (push),
        .push_data (fifo_rd_data),
        .pop       (pop),
        .head_data (m_data),
        .count     (count)
    );

    assign m_valid   = (count != '0);
    assign buf_level = count;

    // Only read latencies 0 and 1 are meaningful for this stage.
    assert property (@(posedge rd_clk) LATENCY_OK);

endmodule

// File: tb/tb_ipm_distributed_fifo_fwft_rd_v1_0.sv
// Self-checking bench: one DUT per read latency (0 and 1), behavioural FIFO plus scoreboard.
module tb_ipm_distributed_fifo_fwft_rd_v1_0;

    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [1:0]    rd_en;
    logic [1:0]    empty = 2'b11;
    logic [1:0]    m_valid;
    logic [1:0]    m_ready = 2'b00;
    logic [1:0]    force_empty = 2'b00;
    logic [DW-1:0] rd_data [2];
    logic [DW-1:0] m_data [2];
    logic [2:0]    buf_level [2];

    logic [DW-1:0] src_q [2][$];
    logic [DW-1:0] exp_q [2][$];
    int            level [2];
    bit            pend [2];
    bit            s_pop [2];
    bit            s_xfer [2];
    bit            s_rst = 1'b1;
    int            delivered [2];
    int            pops [2];
    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;
    bit            mon_en = 1'b0;

    always #5 clk = ~clk;

    ipm_distributed_fifo_fwft_rd_v1_0 #(.DATA_WIDTH(DW), .RD_LATENCY(0)) dut0 (
        .rd_clk       (clk),
        .rd_rst       (rst),
        .fifo_rd_en   (rd_en[0]),
        .fifo_empty   (empty[0]),
        .fifo_rd_data (rd_data[0]),
        .m_data       (m_data[0]),
        .m_valid      (m_valid[0]),
        .m_ready      (m_ready[0]),
        .buf_level    (buf_level[0])
    );

    ipm_distributed_fifo_fwft_rd_v1_0 #(.DATA_WIDTH(DW), .RD_LATENCY(1)) dut1 (
        .rd_clk       (clk),
        .rd_rst       (rst),
        .fifo_rd_en   (rd_en[1]),
        .fifo_empty   (empty[1]),
        .fifo_rd_data (rd_data[1]),
        .m_data       (m_data[1]),
        .m_valid      (m_valid[1]),
        .m_ready      (m_ready[1]),
        .buf_level    (buf_level[1])
    );

    task automatic chk(input string name, input int inst, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("[TB] FAIL %s inst=%0d got=%0h want=%0h cycle=%0d", name, inst, got, want, cyc);
        end
    endtask

    // Advance the reference: FIFO pops taken at the last edge, words landing in the buffer, transfers out.
    task automatic modelUpdate();
        int            landed;
        logic [DW-1:0] w;
        for (int i = 0; i < 2; i++) begin
            if (s_rst) begin
                level[i] = 0;
                pend[i]  = 1'b0;
                exp_q[i].delete();
                src_q[i].delete();
            end else begin
                landed   = (i == 0) ? int'(s_pop[i]) : int'(pend[i]);
                level[i] = level[i] + landed - int'(s_xfer[i]);
                pend[i]  = (i == 1) && s_pop[i];
                if (s_pop[i]) begin
                    w = src_q[i].pop_front();
                    exp_q[i].push_back(w);
                    pops[i]++;
                    if (i == 1) rd_data[1] = w;
                end
            end
        end
    endtask

    task automatic driveFifo();
        for (int i = 0; i < 2; i++) begin
            empty[i] = force_empty[i] | (src_q[i].size() == 0);
        end
        rd_data[0] = (src_q[0].size() != 0) ? src_q[0][0] : '0;
    endtask

    // Just before the active edge: per-cycle checks of pop request, level and valid.
    task automatic checkOutput();
        logic exp_en;
        cyc++;
        for (int i = 0; i < 2; i++) begin
            exp_en = !rst && !empty[i] && ((level[i] + int'(pend[i])) < 4);
            chk("fifo_rd_en", i, 32'(rd_en[i]), 32'(exp_en));
            chk("buf_level", i, 32'(buf_level[i]), level[i]);
            chk("m_valid", i, 32'(m_valid[i]), 32'(level[i] != 0));
            s_pop[i]  = (rd_en[i] === 1'b1) && !empty[i];
            s_xfer[i] = !rst && (m_valid[i] === 1'b1) && m_ready[i];
        end
        s_rst = rst;
    endtask

    task automatic applyStimulus(input logic r, input logic [1:0] rdy, input logic [1:0] fe);
        @(negedge clk);
        modelUpdate();
        rst         = r;
        m_ready     = rdy;
        force_empty = fe;
        driveFifo();
        #4;
        checkOutput();
    endtask

    task automatic doReset();
        applyStimulus(1'b1, 2'b00, 2'b00);
        applyStimulus(1'b0, 2'b00, 2'b00);
    endtask

    task automatic loadCounting(input int n);
        for (int k = 0; k < n; k++) begin
            src_q[0].push_back(DW'(k));
            src_q[1].push_back(DW'(k));
        end
    endtask

    // Scoreboard monitor: head of each stream must match the oldest expected word; pop on transfer.
    always @(negedge clk) begin
        #4;
        if (mon_en && !rst) begin
            for (int i = 0; i < 2; i++) begin
                if (m_valid[i] === 1'b1) begin
                    chk("exp_avail", i, 32'(exp_q[i].size() != 0), 32'd1);
                    if (exp_q[i].size() != 0) begin
                        chk("m_data", i, 32'(m_data[i]), 32'(exp_q[i][0]));
                        if (m_ready[i]) begin
                            void'(exp_q[i].pop_front());
                            delivered[i]++;
                        end
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog inst=0 got=timeout want=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int first_pop [2];
        int first_valid [2];
        int last_xfer [2];
        int d0 [2];
        int k;
        logic [DW-1:0] w;

        rd_data[0] = '0;
        rd_data[1] = '0;
        for (int i = 0; i < 2; i++) begin
            level[i] = 0; pend[i] = 0; s_pop[i] = 0; s_xfer[i] = 0; delivered[i] = 0; pops[i] = 0;
        end
        repeat (3) @(posedge clk);
        mon_en = 1'b1;

        // Reset, then idle with the FIFO empty.
        applyStimulus(1'b1, 2'b00, 2'b00);
        for (int n = 0; n < 10; n++) begin
            applyStimulus(1'b0, 2'b11, 2'b00);
            for (int i = 0; i < 2; i++) chk("idle_m_data", i, 32'(m_data[i]), 32'd0);
        end

        // Burst of 0x00..0x0F with the consumer always ready.
        loadCounting(16);
        for (int i = 0; i < 2; i++) begin
            first_pop[i] = -1; first_valid[i] = -1; last_xfer[i] = -1; d0[i] = delivered[i];
        end
        for (int n = 0; n < 40; n++) begin
            applyStimulus(1'b0, 2'b11, 2'b00);
            for (int i = 0; i < 2; i++) begin
                if (first_pop[i] < 0 && rd_en[i] === 1'b1) first_pop[i] = n;
                if (first_valid[i] < 0 && m_valid[i] === 1'b1) first_valid[i] = n;
                if (m_valid[i] === 1'b1 && m_ready[i]) last_xfer[i] = n;
            end
        end
        for (int i = 0; i < 2; i++) begin
            chk("fill_latency", i, 32'(first_valid[i] - first_pop[i]), 32'(i + 1));
            chk("no_bubbles", i, 32'(last_xfer[i] - first_valid[i]), 32'd15);
            chk("burst_count", i, 32'(delivered[i] - d0[i]), 32'd16);
        end

        // Consumer stalled: exactly four pops, buffer full, head held.
        doReset();
        loadCounting(16);
        pops[0] = 0; pops[1] = 0;
        repeat (10) applyStimulus(1'b0, 2'b00, 2'b00);
        for (int i = 0; i < 2; i++) begin
            chk("stall_pops", i, 32'(pops[i]), 32'd4);
            chk("stall_level", i, 32'(buf_level[i]), 32'd4);
            chk("stall_rd_en", i, 32'(rd_en[i]), 32'd0);
            chk("stall_head", i, 32'(m_data[i]), 32'd0);
        end
        applyStimulus(1'b0, 2'b11, 2'b00);
        repeat (3) applyStimulus(1'b0, 2'b00, 2'b00);
        for (int i = 0; i < 2; i++) begin
            chk("resume_pops", i, 32'(pops[i]), 32'd5);
            chk("resume_level", i, 32'(buf_level[i]), 32'd4);
            chk("resume_head", i, 32'(m_data[i]), 32'd1);
        end

        // Random words, random ready and random empty gaps.
        doReset();
        for (int n = 0; n < 1000; n++) begin
            w = DW'($urandom);
            src_q[0].push_back(w);
            src_q[1].push_back(w);
        end
        d0[0] = delivered[0]; d0[1] = delivered[1];
        k = 0;
        while (k < 8000 && !(src_q[0].size() == 0 && exp_q[0].size() == 0 &&
                             src_q[1].size() == 0 && exp_q[1].size() == 0)) begin
            applyStimulus(1'b0, 2'($urandom),
                          {($urandom_range(0, 4) == 0), ($urandom_range(0, 4) == 0)});
            k++;
        end
        chk("random_done", 0, 32'(k < 8000), 32'd1);
        for (int i = 0; i < 2; i++) chk("random_delivered", i, 32'(delivered[i] - d0[i]), 32'd1000);

        // Empty rises right after a pop: in-flight word still delivered, no further pops.
        doReset();
        loadCounting(5);
        pops[0] = 0; pops[1] = 0;
        d0[0] = delivered[0]; d0[1] = delivered[1];
        applyStimulus(1'b0, 2'b11, 2'b00);
        for (int i = 0; i < 2; i++) chk("edge_pop_issued", i, 32'(rd_en[i]), 32'd1);
        repeat (8) applyStimulus(1'b0, 2'b11, 2'b11);
        for (int i = 0; i < 2; i++) begin
            chk("edge_pops", i, 32'(pops[i]), 32'd1);
            chk("edge_delivered", i, 32'(delivered[i] - d0[i]), 32'd1);
        end

        // Reset with three words buffered and one in flight (latency-1 instance).
        doReset();
        loadCounting(8);
        k = 0;
        while (k < 20 && buf_level[1] !== 3'd3) begin
            applyStimulus(1'b0, 2'b00, 2'b00);
            k++;
        end
        chk("rst_setup_level", 1, 32'(buf_level[1]), 32'd3);
        chk("rst_setup_rd_en", 1, 32'(rd_en[1]), 32'd0);
        applyStimulus(1'b1, 2'b11, 2'b00);
        applyStimulus(1'b0, 2'b11, 2'b00);
        for (int i = 0; i < 2; i++) begin
            chk("post_rst_valid", i, 32'(m_valid[i]), 32'd0);
            chk("post_rst_level", i, 32'(buf_level[i]), 32'd0);
            chk("post_rst_data", i, 32'(m_data[i]), 32'd0);
        end
        d0[0] = delivered[0]; d0[1] = delivered[1];
        repeat (5) applyStimulus(1'b0, 2'b11, 2'b00);
        for (int i = 0; i < 2; i++) chk("post_rst_delivered", i, 32'(delivered[i] - d0[i]), 32'd0);

        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
